// File: rtl/ifm_pingpong_bank_array.sv
// ifm_pingpong_bank_array: two-buffer IFM store with producer/consumer handoff
module ifm_pingpong_bank_array #(
    parameter int DATA_WIDTH       = 32,
    parameter int IFM_SIZE         = 32,
    parameter int NUMBER_OF_IFM    = 3,
    parameter int NUMBER_OF_UNITS  = 4,
    parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int NUMBER_OF_GROUPS = (NUMBER_OF_IFM + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS,
    parameter int SEL_WIDTH        = (NUMBER_OF_GROUPS > 1) ? $clog2(NUMBER_OF_GROUPS) : 1
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [SEL_WIDTH-1:0]                    wr_sel,
    input  logic                                    wr_en,
    input  logic [ADDRESS_SIZE_IFM-1:0]             wr_address,
    input  logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0]   data_in_from_previous,
    input  logic                                    prev_rd_en,
    input  logic [ADDRESS_SIZE_IFM-1:0]             prev_rd_address,
    output logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0]   data_out_for_previous,
    output logic                                    prev_rd_valid,
    input  logic                                    wr_done,
    output logic                                    wr_ready,
    input  logic [SEL_WIDTH-1:0]                    rd_sel,
    input  logic                                    rd_en_A,
    input  logic                                    rd_en_B,
    input  logic [ADDRESS_SIZE_IFM-1:0]             rd_address_A,
    input  logic [ADDRESS_SIZE_IFM-1:0]             rd_address_B,
    output logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0]   data_out_A_for_next,
    output logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0]   data_out_B_for_next,
    output logic                                    rd_valid_A,
    output logic                                    rd_valid_B,
    input  logic                                    rd_done,
    output logic                                    rd_ready,
    output logic [1:0]                              buffer_full,
    output logic                                    handoff_err
);
    localparam int LANES_W = NUMBER_OF_UNITS * DATA_WIDTH;
    localparam int DEPTH   = IFM_SIZE * IFM_SIZE;

    logic [DATA_WIDTH-1:0] mem_q [2][NUMBER_OF_IFM][DEPTH];

    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [1:0]         full_q, full_d;
    logic               err_q, err_d;
    logic [LANES_W-1:0] prev_data_q, prev_data_d;
    logic               prev_valid_q, prev_valid_d;
    logic [LANES_W-1:0] a_data_q, a_data_d;
    logic               a_valid_q, a_valid_d;
    logic [LANES_W-1:0] b_data_q, b_data_d;
    logic               b_valid_q, b_valid_d;
    logic               wr_acc, rd_acc;

    // Gather one group's lanes; lanes with no backing map (or an out-of-range group) stay zero
    function automatic logic [LANES_W-1:0] read_group(
        input logic                        bank,
        input logic [SEL_WIDTH-1:0]        sel,
        input logic [ADDRESS_SIZE_IFM-1:0] addr
    );
        logic [LANES_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUMBER_OF_IFM; i++)
            if (int'(sel) == i / NUMBER_OF_UNITS)
                r[(i % NUMBER_OF_UNITS)*DATA_WIDTH +: DATA_WIDTH] = mem_q[bank][i][addr];
        return r;
    endfunction

    assign wr_ready = !full_q[wr_bank_q];
    assign rd_ready = full_q[rd_bank_q];
    assign wr_acc   = wr_done && wr_ready;
    assign rd_acc   = rd_done && rd_ready;

    // Commit producer writes into the current write bank; masked lanes have no storage
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUMBER_OF_IFM; i++)
            if (wr_en && wr_ready && int'(wr_sel) == i / NUMBER_OF_UNITS)
                mem_q[wr_bank_q][i][wr_address] <= data_in_from_previous[(i % NUMBER_OF_UNITS)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Next-state for handoff flags, bank pointers and registered read ports
    always_comb begin
        full_d       = full_q;
        if (wr_acc) full_d[wr_bank_q] = 1'b1;
        if (rd_acc) full_d[rd_bank_q] = 1'b0;
        wr_bank_d    = wr_acc ? !wr_bank_q : wr_bank_q;
        rd_bank_d    = rd_acc ? !rd_bank_q : rd_bank_q;
        err_d        = err_q || (wr_done && !wr_ready) || (rd_done && !rd_ready);
        prev_valid_d = prev_rd_en;
        prev_data_d  = prev_rd_en ? read_group(wr_bank_q, wr_sel, prev_rd_address) : prev_data_q;
        a_valid_d    = rd_en_A && rd_ready;
        a_data_d     = rd_en_A ? (rd_ready ? read_group(rd_bank_q, rd_sel, rd_address_A) : '0) : a_data_q;
        b_valid_d    = rd_en_B && rd_ready;
        b_data_d     = rd_en_B ? (rd_ready ? read_group(rd_bank_q, rd_sel, rd_address_B) : '0) : b_data_q;
    end

    // State registers; reset drops all handoff state and clears the read ports
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            full_q       <= 2'b00;
            err_q        <= 1'b0;
            prev_data_q  <= '0;
            prev_valid_q <= 1'b0;
            a_data_q     <= '0;
            a_valid_q    <= 1'b0;
            b_data_q     <= '0;
            b_valid_q    <= 1'b0;
        end else begin
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            full_q       <= full_d;
            err_q        <= err_d;
            prev_data_q  <= prev_data_d;
            prev_valid_q <= prev_valid_d;
            a_data_q     <= a_data_d;
            a_valid_q    <= a_valid_d;
            b_data_q     <= b_data_d;
            b_valid_q    <= b_valid_d;
        end
    end

    assign data_out_for_previous = prev_data_q;
    assign prev_rd_valid         = prev_valid_q;
    assign data_out_A_for_next   = a_data_q;
    assign rd_valid_A            = a_valid_q;
    assign data_out_B_for_next   = b_data_q;
    assign rd_valid_B            = b_valid_q;
    assign buffer_full           = full_q;
    assign handoff_err           = err_q;
endmodule

// File: tb/tb_ifm_pingpong_bank_array.sv
// tb_ifm_pingpong_bank_array: scoreboard bench for the ping-pong IFM store
module tb_ifm_pingpong_bank_array;
    localparam int DW = 32;
    localparam int U  = 4;
    localparam int LW = U * DW;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [0:0]    wr_sel = '0, rd_sel = '0;
    logic          wr_en = 0, prev_rd_en = 0, wr_done = 0, rd_done = 0, rd_en_A = 0, rd_en_B = 0;
    logic [AW-1:0] wr_address = '0, prev_rd_address = '0, rd_address_A = '0, rd_address_B = '0;
    logic [LW-1:0] data_in_from_previous = '0;
    logic [LW-1:0] data_out_for_previous, data_out_A_for_next, data_out_B_for_next;
    logic          prev_rd_valid, rd_valid_A, rd_valid_B, wr_ready, rd_ready, handoff_err;
    logic [1:0]    buffer_full;

    int checks = 0;
    int failures = 0;
    logic [LW-1:0] q_prev [$], q_a [$], q_b [$];

    ifm_pingpong_bank_array #(
        .DATA_WIDTH(DW), .IFM_SIZE(4), .NUMBER_OF_IFM(6), .NUMBER_OF_UNITS(U)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_sel(wr_sel), .wr_en(wr_en), .wr_address(wr_address),
        .data_in_from_previous(data_in_from_previous),
        .prev_rd_en(prev_rd_en), .prev_rd_address(prev_rd_address),
        .data_out_for_previous(data_out_for_previous), .prev_rd_valid(prev_rd_valid),
        .wr_done(wr_done), .wr_ready(wr_ready),
        .rd_sel(rd_sel), .rd_en_A(rd_en_A), .rd_en_B(rd_en_B),
        .rd_address_A(rd_address_A), .rd_address_B(rd_address_B),
        .data_out_A_for_next(data_out_A_for_next), .data_out_B_for_next(data_out_B_for_next),
        .rd_valid_A(rd_valid_A), .rd_valid_B(rd_valid_B),
        .rd_done(rd_done), .rd_ready(rd_ready),
        .buffer_full(buffer_full), .handoff_err(handoff_err)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] lanes(input logic [DW-1:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        wr_en = 0; prev_rd_en = 0; rd_en_A = 0; rd_en_B = 0; wr_done = 0; rd_done = 0;
    endtask

    // Monitor: pops an expected word whenever a read port presents valid data
    always @(negedge clk) begin
        if (prev_rd_valid) begin
            if (q_prev.size() == 0) chk("prev_unexpected", 1, 0);
            else chk("prev_data", data_out_for_previous, q_prev.pop_front());
        end
        if (rd_valid_A) begin
            if (q_a.size() == 0) chk("A_unexpected", 1, 0);
            else chk("A_data", data_out_A_for_next, q_a.pop_front());
        end
        if (rd_valid_B) begin
            if (q_b.size() == 0) chk("B_unexpected", 1, 0);
            else chk("B_data", data_out_B_for_next, q_b.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_full", buffer_full, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_err", handoff_err, 0);
        chk("rst_valids", {prev_rd_valid, rd_valid_A, rd_valid_B}, 0);
        chk("rst_prev_data", data_out_for_previous, 0);
        reset_n = 1;
        cycle();
        // bank0: group0 and group1 at addr5, full group0 at addr7
        wr_en = 1; wr_sel = 0; wr_address = 5; data_in_from_previous = lanes(32'h11, 32'h22, 32'h33, 32'h44);
        cycle();
        wr_en = 1; wr_sel = 1; wr_address = 5; data_in_from_previous = lanes(32'hAA, 32'hBB, 32'hCC, 32'hDD);
        cycle();
        prev_rd_en = 1; wr_sel = 0; prev_rd_address = 5; q_prev.push_back(lanes(32'h11, 32'h22, 32'h33, 32'h44));
        cycle();
        prev_rd_en = 1; wr_sel = 1; prev_rd_address = 5; q_prev.push_back(lanes(32'hAA, 32'hBB, 0, 0));
        cycle();
        wr_en = 1; wr_sel = 0; wr_address = 7; data_in_from_previous = lanes(32'h55, 32'h55, 32'h55, 32'h55);
        cycle();
        wr_en = 1; wr_address = 7; data_in_from_previous = lanes(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        prev_rd_en = 1; prev_rd_address = 7; q_prev.push_back(lanes(32'h55, 32'h55, 32'h55, 32'h55));
        cycle();
        prev_rd_en = 1; prev_rd_address = 7; q_prev.push_back(lanes(32'hA0, 32'hA1, 32'hA2, 32'hA3));
        cycle();
        // next-side read before any handoff: zero data, no valid
        rd_en_A = 1; rd_sel = 0; rd_address_A = 5;
        cycle();
        chk("early_A_valid", rd_valid_A, 0);
        chk("early_A_data", data_out_A_for_next, 0);
        wr_done = 1;
        cycle();
        chk("hand1_full", buffer_full, 2'b01);
        chk("hand1_ready", {rd_ready, wr_ready}, 2'b11);
        rd_en_A = 1; rd_en_B = 1; rd_sel = 0; rd_address_A = 5; rd_address_B = 5;
        q_a.push_back(lanes(32'h11, 32'h22, 32'h33, 32'h44));
        q_b.push_back(lanes(32'h11, 32'h22, 32'h33, 32'h44));
        cycle();
        rd_en_A = 1; rd_sel = 1; rd_address_A = 5; q_a.push_back(lanes(32'hAA, 32'hBB, 0, 0));
        cycle();
        cycle();
        chk("A_hold", data_out_A_for_next, lanes(32'hAA, 32'hBB, 0, 0));
        // fill bank1 and hand it off
        wr_en = 1; wr_sel = 0; wr_address = 5; data_in_from_previous = lanes(32'h91, 32'h92, 32'h93, 32'h94);
        cycle();
        wr_done = 1;
        cycle();
        chk("hand2_full", buffer_full, 2'b11);
        chk("hand2_wr_ready", wr_ready, 0);
        wr_en = 1; wr_sel = 0; wr_address = 5; data_in_from_previous = lanes(32'hEE, 32'hEE, 32'hEE, 32'hEE);
        cycle();
        chk("drop_no_err", handoff_err, 0);
        wr_done = 1;
        cycle();
        chk("extra_done_err", handoff_err, 1);
        chk("extra_done_full", buffer_full, 2'b11);
        rd_en_A = 1; rd_sel = 0; rd_address_A = 5; q_a.push_back(lanes(32'h11, 32'h22, 32'h33, 32'h44));
        cycle();
        rd_done = 1; wr_done = 1;
        cycle();
        chk("simul_full", buffer_full, 2'b10);
        chk("simul_ready", {rd_ready, wr_ready}, 2'b11);
        chk("simul_err", handoff_err, 1);
        rd_en_B = 1; rd_sel = 0; rd_address_B = 5; q_b.push_back(lanes(32'h91, 32'h92, 32'h93, 32'h94));
        cycle();
        cycle();
        // asynchronous reset while a read is returning
        rd_en_A = 1; rd_sel = 0; rd_address_A = 5;
        cycle();
        #1;
        reset_n = 0;
        #1;
        chk("arst_full", buffer_full, 0);
        chk("arst_err", handoff_err, 0);
        chk("arst_valids", {prev_rd_valid, rd_valid_A, rd_valid_B, rd_ready}, 0);
        chk("arst_A_data", data_out_A_for_next, 0);
        for (int i = 0; i < 10 && (q_prev.size() + q_a.size() + q_b.size()) != 0; i++) @(posedge clk);
        chk("queues_drained", q_prev.size() + q_a.size() + q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifm_pingpong_bank_array.md
Name: ifm_pingpong_bank_array

Overview:
Parametrised successor of the single-buffer IFM memory array. It holds NUMBER_OF_IFM input feature maps in two ping-pong buffers. The previous layer fills and accumulates into the write buffer, one group of NUMBER_OF_UNITS maps at a time, while the next layer reads the other buffer through dual A/B ports. A buffer-handoff handshake (full flags) sits between the producer and consumer layers. Unused lanes of the last group are masked.

Parameters:
DATA_WIDTH, 32, word width
IFM_SIZE, 32, map edge; each map holds IFM_SIZE*IFM_SIZE words
NUMBER_OF_IFM, 3, maps stored per buffer
NUMBER_OF_UNITS, 4, lanes per group
ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), address width
NUMBER_OF_GROUPS, ceil(NUMBER_OF_IFM/NUMBER_OF_UNITS), groups per buffer
SEL_WIDTH, max(1,$clog2(NUMBER_OF_GROUPS)), group-select width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
wr_sel  in  SEL_WIDTH  group for write side and previous-read port
wr_en  in  1  write lanes at wr_address
wr_address  in  ADDRESS_SIZE_IFM  write address
data_in_from_previous  in  NUMBER_OF_UNITS*DATA_WIDTH  lane u in bits [u*DW +: DW]
prev_rd_en  in  1  read write buffer (partial-sum fetch)
prev_rd_address  in  ADDRESS_SIZE_IFM  previous-read address
data_out_for_previous  out  NUMBER_OF_UNITS*DATA_WIDTH  previous-read data
prev_rd_valid  out  1  previous-read data valid
wr_done  in  1  pulse: write buffer complete, hand off
wr_ready  out  1  write buffer free (not full)
rd_sel  in  SEL_WIDTH  group for next-side reads
rd_en_A, rd_en_B  in  1 each  next-side read enables
rd_address_A, rd_address_B  in  ADDRESS_SIZE_IFM each  next-side addresses
data_out_A_for_next, data_out_B_for_next  out  NUMBER_OF_UNITS*DATA_WIDTH each  next-side data
rd_valid_A, rd_valid_B  out  1 each  next-side data valid
rd_done  in  1  pulse: read buffer consumed, release
rd_ready  out  1  read buffer holds a complete layer
buffer_full  out  2  full flag per buffer
handoff_err  out  1  sticky; wr_done/rd_done issued while not ready

Behaviour:
- Storage: 2 buffers × NUMBER_OF_IFM maps. Lane u of group g maps to m = g*NUMBER_OF_UNITS+u.
- Masking: lanes with m >= NUMBER_OF_IFM ignore writes and return 0. The same applies to every lane when the sel value is >= NUMBER_OF_GROUPS.
- Bank pointers: wr_bank and rd_bank, both 0 at reset.
  - wr_ready = !buffer_full[wr_bank]
  - rd_ready = buffer_full[rd_bank]
- Write: on wr_en && wr_ready, each valid lane writes map m of wr_bank at wr_address. wr_en while !wr_ready is dropped (no memory change) and does not flag an error.
- Previous read: reads wr_bank. 1-cycle latency: data and prev_rd_valid are registered at the edge after prev_rd_en. Read-first: a read and write to the same address in the same cycle returns the old word.
- Next reads: ports A and B independently read rd_bank at their addresses, with 1-cycle latency. rd_valid_X = registered rd_en_X && rd_ready. Reads while !rd_ready return 0 with valid low. A and B may use the same address; both return the same word.
- Data hold: output data holds its last value while valid is low, except in the cases above that are defined to return 0.
- Handoff:
  - wr_done && wr_ready: set buffer_full[wr_bank], toggle wr_bank next edge.
  - rd_done && rd_ready: clear buffer_full[rd_bank], toggle rd_bank.
  - Simultaneous wr_done and rd_done: both take effect in the same edge. Because wr_bank != rd_bank whenever both are ready, there is no conflict.
  - wr_done with !wr_ready, or rd_done with !rd_ready: ignored, and handoff_err sets. handoff_err is cleared only by reset.
- Ordering: a write and a wr_done in the same cycle commit the write to the old wr_bank before the toggle.
- Reset (async assert, sync deassert assumed upstream):
  - All outputs 0, valids 0, buffer_full=00, pointers 0, handoff_err 0.
  - Memory contents are undefined and not cleared.
  - Reset mid-transfer discards all handoff state.

Test Plan:
- Reset, write lanes 0..2 = 0x11,0x22,0x33 at addr 5, wr_sel=0; prev_rd addr 5 → next cycle data lanes 0x11/0x22/0x33, lane3=0, prev_rd_valid=1.
- wr_done → buffer_full=01, rd_ready=1, wr_ready=1 (bank1 free). rd_en_A addr5 and rd_en_B addr5 → both 0x22 on lane1, valids 1.
- Fill bank1, wr_done → wr_ready=0, buffer_full=11. A further wr_en is dropped; a further wr_done sets handoff_err=1.
- With both banks full, rd_done → buffer_full=10 and rd_ready stays 1 (bank1). A simultaneous wr_done in that same cycle has no free bank, so it is rejected: flag set and buffer_full=10.
- Same-cycle write 0xAA and prev_rd at addr 7 (old 0x55) → prev data 0x55. Next-cycle read → 0xAA.
- NUMBER_OF_IFM=6, UNITS=4: wr_sel=1 writes lanes 0,1 only. rd_sel=1 lanes 2,3 read 0. Assert reset_n low mid-stream → all flags and valids 0 immediately.
